ps2_rx_scheduler: RTL
=====================

# ps2_rx_scheduler

Front-end controller for the keyboard path: receives PS/2 device-to-host frames, validates them, buffers scancode bytes in a small FIFO, and issues them one at a time to the scancode decoder/display FSM. Delivery uses a one-cycle `rec_flag` strobe with a stable data byte and a guaranteed minimum gap between strobes, so the downstream FSM sees every byte, including 0xF0 break prefixes. Sits between the board PS/2 pins and the keyboard display logic.

## Interface
- `FIFO_DEPTH`, default 8: byte-FIFO entries; power of two, ≥2.
- `FILTER_LEN`, default 4: consecutive equal synchronized samples needed to accept a new ps2_clk level.
- `TIMEOUT_CYC`, default 10000: maximum clk cycles between ps2_clk falling edges inside a frame.
- `MIN_GAP`, default 4: minimum clk cycles from one `rec_flag` to the next; ≥2.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset; one clock; reset is asynchronous and active-low.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `rec_data` out 8: last delivered byte; held until the next delivery.
- `rec_flag` out 1: one-cycle strobe; `rec_data` is valid in the same cycle.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: sticky; a valid byte was dropped because the FIFO was full.
- `ovf_clr` in 1: clears `overflow`.
- `err_cnt` out 8: count of rejected frames, saturating at 0xFF.

## Operation
- **Input conditioning:** two-flop synchronizer on both pins. `ps2_clk` passes through a FILTER_LEN-sample glitch filter. A falling edge means the filtered level goes 1→0; `ps2_data` is sampled from its synchronizer in that cycle.
- **Receiver FSM (RX_IDLE, RX_DATA, RX_PARITY, RX_STOP):**
  - RX_IDLE: on a falling edge, if data=0, load the bit index with 0 and go to RX_DATA. If data=1 (bad start), increment `err_cnt` and stay in RX_IDLE.
  - RX_DATA: shift data in LSB first. After the 8th bit, go to RX_PARITY.
  - RX_PARITY: capture the parity bit and go to RX_STOP.
  - RX_STOP: on the edge, the frame is good if stop=1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity). Good frame: push the byte. Bad frame: increment `err_cnt`. Either way, go to RX_IDLE.
  - Timeout: a counter is cleared on each falling edge and runs in any state other than RX_IDLE. When it reaches TIMEOUT_CYC, return to RX_IDLE, increment `err_cnt` and discard the partial byte.
- **FIFO push rules:**
  - Push is accepted if level < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `overflow` is set.
  - If `ovf_clr` and a new drop occur in the same cycle, set wins.
- **Scheduler:**
  - Gap counter `gap`: when `rec_flag` fires it loads MIN_GAP-1, then decrements to 0.
  - Pop condition: level ≠ 0 and gap = 0. On a pop, the registered `rec_data` takes the FIFO head and `rec_flag` is 1 for exactly one cycle.
- **Reset values:** `rec_data`=0x00, `rec_flag`=0, `fifo_level`=0, `overflow`=0, `err_cnt`=0x00, FSM=RX_IDLE, gap=0, pointers=0. Reset mid-frame discards the partial frame and all FIFO contents.

## Timing
- Stop-bit edge detected in cycle N: FIFO write at end of N. If the FIFO was empty and gap=0, `rec_flag`=1 in cycle N+1.
- Back-to-back buffered bytes: `rec_flag` pulses exactly MIN_GAP cycles apart.
- `fifo_level` updates at the clock edge after the push/pop; a simultaneous push and pop leaves it unchanged.
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. Full/empty are derived from `fifo_level`.
- `err_cnt` and `overflow` update one cycle after the causing event.

## Structure
- Shared package `ps2_pkg`: RX state enum, frame length constant (11), default PS/2 timing constants.
- Sub-module `ps2_byte_fifo`: synchronous single-clock FIFO with level output, parameterized by depth.
- Synchronizer, filter, receiver FSM and scheduler stay in the top module.

## Test plan
- **Single frame:** send 0x1C with correct parity (bits 0,0,1,1,1,0,0,0, parity 0, stop 1) → one `rec_flag` with `rec_data`=0x1C; `err_cnt`=0.
- **Make/break burst:** frames 0x1C, 0xF0, 0x1C sent fast, downstream idle → three strobes in order, each exactly MIN_GAP apart once buffered; `fifo_level` returns to 0.
- **Bad parity or stop:** 0x1C with parity=1, then 0x1C with stop=0 → no strobe; `err_cnt`=2.
- **Overflow:** hold the scheduler busy (MIN_GAP=64 variant), send 10 frames with FIFO_DEPTH=8 → `overflow`=1. The first 9 bytes are delivered in order (one popped early frees a slot). Pulsing `ovf_clr` clears `overflow`.
- **Timeout:** stop ps2_clk after 4 data bits for more than TIMEOUT_CYC → FSM in RX_IDLE; `err_cnt` incremented by 1. The next good frame 0x45 is delivered correctly.
- **Reset mid-operation:** assert `rst` low mid-frame with 3 bytes buffered → all outputs at reset values. No strobe until a new complete frame arrives.

Source files
------------

// File: rtl/ps2_pkg.sv
// PS/2 receive path shared definitions: receiver states, frame geometry, default timing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

  // Device-to-host frame: start, 8 data bits (LSB first), odd parity, stop
  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  // Defaults sized for a 10-16.7 kHz PS/2 clock against a tens-of-MHz system clock
  localparam int PS2_FIFO_DEPTH_DEF  = 8;
  localparam int PS2_FILTER_LEN_DEF  = 4;
  localparam int PS2_TIMEOUT_CYC_DEF = 10000;
  localparam int PS2_MIN_GAP_DEF     = 4;

  // Error counter increments stick at all-ones instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Single-clock byte FIFO with occupancy output and fall-through when empty.
// Latency: write visible at head the next cycle; when empty a same-cycle push is poppable at once.
// Backpressure: a push into a full FIFO is dropped (o_drop) unless a pop happens in the same cycle.
module ps2_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_vld,
  input  logic [7:0]             i_wr_dat,
  input  logic                   i_rd,
  output logic                   o_rd_vld,
  output logic [7:0]             o_head,
  output logic                   o_drop,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == LW'(DEPTH));
  // An empty FIFO can still hand out the byte arriving this cycle
  assign o_rd_vld = !w_empty || i_wr_vld;
  assign w_pop    = i_rd && o_rd_vld;
  // A pop frees the slot the push needs, so full is not a drop in that case
  assign w_push   = i_wr_vld && (!w_full || w_pop);
  assign o_drop   = i_wr_vld && !w_push;
  assign o_head   = w_empty ? i_wr_dat : r_mem[r_rd_ptr];
  assign o_level  = r_level;

  // Storage array; when full with a pop, the overwritten slot is the one being read out
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_dat;
    end
  end

  // Pointers wrap naturally; occupancy tracks push/pop and is the sole full/empty source
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_scheduler.sv
// PS/2 frame receiver, validator and paced byte issuer for the scancode decoder.
// Latency: stop-bit edge in cycle N gives rec_flag in N+1 when idle (edge itself lags the pin by sync+filter).
// Backpressure: none downstream; bytes queue in the FIFO, excess bytes are dropped and flagged sticky.
module ps2_rx_scheduler
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = PS2_FIFO_DEPTH_DEF,
  parameter int FILTER_LEN  = PS2_FILTER_LEN_DEF,
  parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC_DEF,
  parameter int MIN_GAP     = PS2_MIN_GAP_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_ps2_clk,
  input  logic                        i_ps2_data,
  output logic [7:0]                  o_rec_data,
  output logic                        o_rec_flag,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
  output logic                        o_overflow,
  input  logic                        i_ovf_clr,
  output logic [7:0]                  o_err_cnt
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(MIN_GAP);

  // Conditioning
  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic [FW-1:0] r_filt_cnt;
  logic          r_filt_lvl;
  logic          r_filt_prev;
  logic          w_fall;
  logic          w_ps2_bit;

  // Receiver
  rx_state_t     r_state;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_err_cnt;
  logic          w_frame_ok;
  logic          w_push;

  // FIFO and scheduler
  logic          w_rd_vld;
  logic [7:0]    w_head;
  logic          w_drop;
  logic [LW-1:0] w_level;
  logic          w_pop;
  logic [GW-1:0] r_gap;
  logic          r_rec_flag;
  logic [7:0]    r_rec_data;
  logic          r_overflow;

  // Two-flop synchronizers; idle bus level is high on both lines
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_data};
    end
  end

  // Glitch filter: a new ps2_clk level needs FILTER_LEN consecutive agreeing samples
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_filt_cnt  <= '0;
      r_filt_lvl  <= 1'b1;
      r_filt_prev <= 1'b1;
    end else begin
      r_filt_prev <= r_filt_lvl;
      if (r_clk_sync[1] == r_filt_lvl) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt_lvl <= r_clk_sync[1];
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

  assign w_fall    = r_filt_prev && !r_filt_lvl;
  assign w_ps2_bit = r_dat_sync[1];

  // Stop bit high and odd parity over data+parity; push decided in the stop-edge cycle itself
  assign w_frame_ok = w_ps2_bit && (^{r_shift, r_parity});
  assign w_push     = w_fall && (r_state == RX_STOP) && w_frame_ok;

  // Receiver FSM with inter-edge watchdog and saturating reject counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= RX_IDLE;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_to_cnt  <= '0;
      r_err_cnt <= '0;
    end else if (w_fall) begin
      r_to_cnt <= '0;
      case (r_state)
        RX_IDLE: begin
          if (!w_ps2_bit) begin
            r_bit_idx <= '0;
            r_state   <= RX_DATA;
          end else begin
            r_err_cnt <= sat_inc8(r_err_cnt);
          end
        end
        RX_DATA: begin
          r_shift <= {w_ps2_bit, r_shift[7:1]};
          if (r_bit_idx == 3'(PS2_DATA_BITS - 1)) begin
            r_state <= RX_PARITY;
          end else begin
            r_bit_idx <= r_bit_idx + 3'd1;
          end
        end
        RX_PARITY: begin
          r_parity <= w_ps2_bit;
          r_state  <= RX_STOP;
        end
        RX_STOP: begin
          if (!w_frame_ok) r_err_cnt <= sat_inc8(r_err_cnt);
          r_state <= RX_IDLE;
        end
        default: r_state <= RX_IDLE;
      endcase
    end else if (r_state != RX_IDLE) begin
      if (r_to_cnt == TW'(TIMEOUT_CYC)) begin
        // Device went quiet mid-frame: drop the partial byte and resync on the next start bit
        r_state   <= RX_IDLE;
        r_shift   <= '0;
        r_to_cnt  <= '0;
        r_err_cnt <= sat_inc8(r_err_cnt);
      end else begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end
    end
  end

  ps2_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_wr_vld (w_push),
    .i_wr_dat (r_shift),
    .i_rd     (w_pop),
    .o_rd_vld (w_rd_vld),
    .o_head   (w_head),
    .o_drop   (w_drop),
    .o_level  (w_level)
  );

  // Issue a byte whenever one is available and the spacing window has closed
  assign w_pop = w_rd_vld && (r_gap == '0);

  // Delivery register and gap counter; gap reloads with each strobe so strobes sit MIN_GAP apart
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rec_flag <= 1'b0;
      r_rec_data <= '0;
      r_gap      <= '0;
    end else if (w_pop) begin
      r_rec_flag <= 1'b1;
      r_rec_data <= w_head;
      r_gap      <= GW'(MIN_GAP - 1);
    end else begin
      r_rec_flag <= 1'b0;
      if (r_gap != '0) r_gap <= r_gap - GW'(1);
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (i_ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign o_rec_data   = r_rec_data;
  assign o_rec_flag   = r_rec_flag;
  assign o_fifo_level = w_level;
  assign o_overflow   = r_overflow;
  assign o_err_cnt    = r_err_cnt;

endmodule
